// File: rtl/match_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : match_sequencer
// Purpose  : Game-flow controller for the paddle game: phases, scores,
//            countdown clock and ball motion gating, advanced per frame.
// Revision : 1.0 - initial release
// ============================================================================
module match_sequencer #(
    parameter int WIN_SCORE     = 9,
    parameter int MATCH_SECONDS = 60,
    parameter int TICKS_PER_SEC = 60,
    parameter int SERVE_FRAMES  = 90,
    parameter int POINT_FRAMES  = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refresh_tick,
    input  logic       start_pulse,
    input  logic       pause_pulse,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic [2:0] state,
    output logic       ball_run,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [3:0] score_player1,
    output logic [3:0] score_player2,
    output logic [5:0] seconds,
    output logic [1:0] winner
);

    localparam int C_FRAME_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int C_FW        = $clog2(C_FRAME_MAX + 1);
    localparam int C_SW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    localparam logic [C_FW-1:0] C_SERVE_LAST = C_FW'(SERVE_FRAMES - 1);
    localparam logic [C_FW-1:0] C_POINT_LAST = C_FW'(POINT_FRAMES - 1);
    localparam logic [C_SW-1:0] C_TPS_LAST   = C_SW'(TICKS_PER_SEC - 1);
    localparam logic [3:0]      C_WIN        = 4'(WIN_SCORE);
    localparam logic [5:0]      C_SECONDS    = 6'(MATCH_SECONDS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_PAUSE = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    state_t          r_state;
    logic            r_ball_run;
    logic            r_ball_reset;
    logic            r_serve_dir;
    logic [3:0]      r_score_p1;
    logic [3:0]      r_score_p2;
    logic [5:0]      r_seconds;
    logic [1:0]      r_winner;
    logic [C_FW-1:0] r_frame_cnt;
    logic [C_SW-1:0] r_sec_cnt;

    logic            w_sec_wrap;
    logic [C_SW-1:0] w_sec_cnt_nxt;
    logic [5:0]      w_seconds_nxt;
    logic            w_expire;
    logic            w_left_only;
    logic            w_right_only;
    logic            w_any_miss;
    logic [3:0]      w_p1_nxt;
    logic [3:0]      w_p2_nxt;
    logic            w_p1_wins;
    logic            w_p2_wins;
    logic [1:0]      w_cmp_winner;
    logic [C_FW-1:0] w_frame_inc;

    // Next-value helpers for the PLAY phase; the FSM decides which ones commit.
    always_comb begin
        w_sec_wrap    = refresh_tick && (r_sec_cnt == C_TPS_LAST);
        w_sec_cnt_nxt = r_sec_cnt;
        if (refresh_tick) begin
            w_sec_cnt_nxt = w_sec_wrap ? '0 : r_sec_cnt + C_SW'(1);
        end
        w_seconds_nxt = r_seconds;
        if (w_sec_wrap && (r_seconds != 6'd0)) begin
            w_seconds_nxt = r_seconds - 6'd1;
        end
        w_expire = w_sec_wrap && (r_seconds == 6'd1);

        w_left_only  = miss_left && !miss_right;
        w_right_only = miss_right && !miss_left;
        w_any_miss   = miss_left || miss_right;

        w_p1_nxt = r_score_p1;
        if (w_right_only && (r_score_p1 < C_WIN)) begin
            w_p1_nxt = r_score_p1 + 4'd1;
        end
        w_p2_nxt = r_score_p2;
        if (w_left_only && (r_score_p2 < C_WIN)) begin
            w_p2_nxt = r_score_p2 + 4'd1;
        end
        w_p1_wins = w_right_only && (w_p1_nxt == C_WIN);
        w_p2_wins = w_left_only && (w_p2_nxt == C_WIN);

        // Timeout verdict uses the scores as updated in this same cycle.
        if (w_p1_nxt > w_p2_nxt) begin
            w_cmp_winner = 2'b01;
        end else if (w_p2_nxt > w_p1_nxt) begin
            w_cmp_winner = 2'b10;
        end else begin
            w_cmp_winner = 2'b11;
        end

        w_frame_inc = r_frame_cnt + C_FW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_ball_run   <= 1'b0;
            r_ball_reset <= 1'b0;
            r_serve_dir  <= 1'b0;
            r_score_p1   <= 4'd0;
            r_score_p2   <= 4'd0;
            r_seconds    <= C_SECONDS;
            r_winner     <= 2'b00;
            r_frame_cnt  <= '0;
            r_sec_cnt    <= '0;
        end else begin
            r_ball_reset <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_pulse) begin
                        r_score_p1   <= 4'd0;
                        r_score_p2   <= 4'd0;
                        r_winner     <= 2'b00;
                        r_frame_cnt  <= '0;
                        r_sec_cnt    <= '0;
                        r_seconds    <= C_SECONDS;
                        r_ball_reset <= 1'b1;
                        r_state      <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (refresh_tick) begin
                        if (r_frame_cnt == C_SERVE_LAST) begin
                            r_frame_cnt <= '0;
                            r_ball_run  <= 1'b1;
                            r_state     <= ST_PLAY;
                        end else begin
                            r_frame_cnt <= w_frame_inc;
                        end
                    end
                end
                ST_PLAY: begin
                    r_sec_cnt  <= w_sec_cnt_nxt;
                    r_seconds  <= w_seconds_nxt;
                    r_score_p1 <= w_p1_nxt;
                    r_score_p2 <= w_p2_nxt;
                    // Priority: miss, then timer expiry, then pause.
                    if (w_any_miss) begin
                        if (w_left_only) begin
                            r_serve_dir <= 1'b0;
                        end
                        if (w_right_only) begin
                            r_serve_dir <= 1'b1;
                        end
                        r_ball_run <= 1'b0;
                        if (w_p1_wins) begin
                            r_winner <= 2'b01;
                            r_state  <= ST_OVER;
                        end else if (w_p2_wins) begin
                            r_winner <= 2'b10;
                            r_state  <= ST_OVER;
                        end else if (w_expire) begin
                            r_winner <= w_cmp_winner;
                            r_state  <= ST_OVER;
                        end else begin
                            r_frame_cnt <= '0;
                            r_state     <= ST_POINT;
                        end
                    end else if (w_expire) begin
                        r_ball_run <= 1'b0;
                        r_winner   <= w_cmp_winner;
                        r_state    <= ST_OVER;
                    end else if (pause_pulse) begin
                        r_ball_run <= 1'b0;
                        r_state    <= ST_PAUSE;
                    end
                end
                ST_POINT: begin
                    if (refresh_tick) begin
                        if (r_frame_cnt == C_POINT_LAST) begin
                            r_frame_cnt  <= '0;
                            r_ball_reset <= 1'b1;
                            r_state      <= ST_SERVE;
                        end else begin
                            r_frame_cnt <= w_frame_inc;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (pause_pulse) begin
                        r_ball_run <= 1'b1;
                        r_state    <= ST_PLAY;
                    end
                end
                ST_OVER: begin
                    if (start_pulse) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_ball_run <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign state         = r_state;
    assign ball_run      = r_ball_run;
    assign ball_reset    = r_ball_reset;
    assign serve_dir     = r_serve_dir;
    assign score_player1 = r_score_p1;
    assign score_player2 = r_score_p2;
    assign seconds       = r_seconds;
    assign winner        = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_match_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_match_sequencer
// Purpose  : Directed scenarios plus random play for match_sequencer,
//            checked every cycle against a tick-count based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_match_sequencer;

    localparam int TPS = 2;
    localparam int SF  = 3;
    localparam int PF  = 2;
    localparam int MS  = 5;
    localparam int WIN = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       refresh_tick = 1'b0;
    logic       start_pulse = 1'b0;
    logic       pause_pulse = 1'b0;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic [2:0] state;
    logic       ball_run;
    logic       ball_reset;
    logic       serve_dir;
    logic [3:0] score_player1;
    logic [3:0] score_player2;
    logic [5:0] seconds;
    logic [1:0] winner;

    int errors = 0;
    int checks = 0;

    // Reference model: phase, scores and total ticks spent in PLAY since start.
    int m_state, m_s1, m_s2, m_dir, m_win, m_ball_reset;
    int m_play_ticks, m_phase_ticks;

    match_sequencer #(
        .WIN_SCORE    (WIN),
        .MATCH_SECONDS(MS),
        .TICKS_PER_SEC(TPS),
        .SERVE_FRAMES (SF),
        .POINT_FRAMES (PF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .refresh_tick (refresh_tick),
        .start_pulse  (start_pulse),
        .pause_pulse  (pause_pulse),
        .miss_left    (miss_left),
        .miss_right   (miss_right),
        .state        (state),
        .ball_run     (ball_run),
        .ball_reset   (ball_reset),
        .serve_dir    (serve_dir),
        .score_player1(score_player1),
        .score_player2(score_player2),
        .seconds      (seconds),
        .winner       (winner)
    );

    always #5 clk = ~clk;

    function automatic int decide();
        if (m_s1 > m_s2) return 1;
        if (m_s2 > m_s1) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_state = 0; m_s1 = 0; m_s2 = 0; m_dir = 0; m_win = 0;
        m_ball_reset = 0; m_play_ticks = 0; m_phase_ticks = 0;
    endtask

    task automatic model_step(input bit tk, input bit st, input bit ps,
                              input bit ml, input bit mr);
        bit expired;
        bit scored_win;
        m_ball_reset = 0;
        expired = 0;
        scored_win = 0;
        case (m_state)
            0: if (st) begin
                m_s1 = 0; m_s2 = 0; m_win = 0;
                m_play_ticks = 0; m_phase_ticks = 0;
                m_state = 1; m_ball_reset = 1;
            end
            1: if (tk) begin
                m_phase_ticks++;
                if (m_phase_ticks == SF) begin m_state = 2; m_phase_ticks = 0; end
            end
            2: begin
                if (tk) m_play_ticks++;
                expired = tk && (m_play_ticks == MS * TPS);
                if (ml && !mr) begin
                    m_dir = 0;
                    if (m_s2 < WIN) m_s2++;
                    if (m_s2 == WIN) begin scored_win = 1; m_win = 2; end
                end
                if (mr && !ml) begin
                    m_dir = 1;
                    if (m_s1 < WIN) m_s1++;
                    if (m_s1 == WIN) begin scored_win = 1; m_win = 1; end
                end
                if (ml || mr) begin
                    if (scored_win) m_state = 5;
                    else if (expired) begin m_state = 5; m_win = decide(); end
                    else begin m_state = 3; m_phase_ticks = 0; end
                end else if (expired) begin
                    m_state = 5; m_win = decide();
                end else if (ps) begin
                    m_state = 4;
                end
            end
            3: if (tk) begin
                m_phase_ticks++;
                if (m_phase_ticks == PF) begin
                    m_state = 1; m_phase_ticks = 0; m_ball_reset = 1;
                end
            end
            4: if (ps) m_state = 2;
            5: if (st) m_state = 0;
            default: m_state = 0;
        endcase
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input int exp);
        checks++;
        assert (obs === 8'(exp)) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("state", {5'd0, state}, m_state);
        chk("ball_run", {7'd0, ball_run}, (m_state == 2) ? 1 : 0);
        chk("ball_reset", {7'd0, ball_reset}, m_ball_reset);
        chk("serve_dir", {7'd0, serve_dir}, m_dir);
        chk("score_player1", {4'd0, score_player1}, m_s1);
        chk("score_player2", {4'd0, score_player2}, m_s2);
        chk("seconds", {2'd0, seconds}, MS - m_play_ticks / TPS);
        chk("winner", {6'd0, winner}, m_win);
    endtask

    // Called at posedge+1; drives one cycle of inputs and checks the result.
    task automatic step(input bit tk, input bit st, input bit ps,
                        input bit ml, input bit mr);
        refresh_tick = tk; start_pulse = st; pause_pulse = ps;
        miss_left = ml; miss_right = mr;
        model_step(tk, st, ps, ml, mr);
        @(posedge clk);
        #1;
        refresh_tick = 0; start_pulse = 0; pause_pulse = 0;
        miss_left = 0; miss_right = 0;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
    endtask

    task automatic point_to_play();
        ticks(PF);
        ticks(SF);
    endtask

    initial begin
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_all();
        chk("reset_seconds", {2'd0, seconds}, 5);
        reset = 1'b1;
        step(0, 0, 0, 0, 0);

        // Reset and start
        step(0, 1, 0, 0, 0);
        chk("start_state", {5'd0, state}, 1);
        chk("start_ball_reset", {7'd0, ball_reset}, 1);
        step(0, 0, 0, 0, 0);
        chk("ball_reset_one_cycle", {7'd0, ball_reset}, 0);
        ticks(2);
        chk("serve_held", {5'd0, state}, 1);
        ticks(1);
        chk("serve_to_play", {5'd0, state}, 2);
        chk("play_ball_run", {7'd0, ball_run}, 1);

        // Point cycle
        step(0, 0, 0, 0, 1);
        chk("point_p1", {4'd0, score_player1}, 1);
        chk("point_dir", {7'd0, serve_dir}, 1);
        chk("point_state", {5'd0, state}, 3);
        ticks(2);
        chk("reserve_state", {5'd0, state}, 1);
        chk("reserve_ball_reset", {7'd0, ball_reset}, 1);
        ticks(SF);

        // Win for player 2
        step(0, 0, 0, 1, 0); point_to_play();
        step(0, 0, 0, 1, 0); point_to_play();
        step(0, 0, 0, 1, 0);
        chk("win_state", {5'd0, state}, 5);
        chk("win_winner", {6'd0, winner}, 2);
        chk("win_p2", {4'd0, score_player2}, 3);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1);
        chk("over_hold_p1", {4'd0, score_player1}, 1);
        chk("over_hold_p2", {4'd0, score_player2}, 3);

        // Timeout draw
        step(0, 1, 0, 0, 0);
        chk("over_to_idle", {5'd0, state}, 0);
        step(0, 1, 0, 0, 0);
        chk("restart_clear_p1", {4'd0, score_player1}, 0);
        ticks(SF);
        step(0, 0, 0, 0, 1); point_to_play();
        step(0, 0, 0, 1, 0); point_to_play();
        ticks(2);
        chk("draw_seconds_4", {2'd0, seconds}, 4);
        ticks(8);
        chk("draw_seconds_0", {2'd0, seconds}, 0);
        chk("draw_state", {5'd0, state}, 5);
        chk("draw_winner", {6'd0, winner}, 3);

        // Pause mid-second
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        ticks(SF);
        ticks(3);
        chk("pre_pause_seconds", {2'd0, seconds}, 4);
        step(0, 0, 1, 0, 0);
        chk("pause_state", {5'd0, state}, 4);
        chk("pause_ball_run", {7'd0, ball_run}, 0);
        ticks(5);
        step(1, 0, 0, 1, 0);
        chk("paused_seconds", {2'd0, seconds}, 4);
        chk("paused_p2", {4'd0, score_player2}, 0);
        step(0, 0, 1, 0, 0);
        chk("resume_state", {5'd0, state}, 2);
        ticks(1);
        chk("resume_seconds", {2'd0, seconds}, 3);

        // Simultaneous misses, then async reset in POINT
        step(0, 0, 0, 1, 1);
        chk("dual_miss_state", {5'd0, state}, 3);
        chk("dual_miss_p1", {4'd0, score_player1}, 0);
        chk("dual_miss_p2", {4'd0, score_player2}, 0);
        ticks(1);
        reset = 1'b0;
        #2;
        model_reset();
        check_all();
        chk("async_reset_state", {5'd0, state}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_all();

        // Random play against the model
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 14) == 0,
                 $urandom_range(0, 14) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
